// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, writeback-select encoding and load funct3 codes
package riscv_pkg;
    localparam int REGF_WIDTH = 32;
    localparam int IS_DEPTH = 5;
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4 = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_e;
    localparam logic [2:0] F3_LB = 3'b000;
    localparam logic [2:0] F3_LH = 3'b001;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/load_extend.sv
// load_extend: little-endian byte/half selection with sign/zero extension and fault detection
module load_extend
    import riscv_pkg::*;
#(
    parameter int W = riscv_pkg::REGF_WIDTH
) (
    input  logic [W-1:0] word,
    input  logic [1:0]   addr,
    input  logic [2:0]   funct3,
    output logic [W-1:0] value,
    output logic         bad
);
    logic [7:0] b;
    logic [15:0] h;
    logic illegal;
    logic misaligned;
    assign b = word[{addr, 3'b000} +: 8];
    assign h = word[{addr[1], 4'b0000} +: 16];
    // select the extended value for each legal load type
    always_comb begin
        value = funct3 == F3_LB  ? {{(W-8){b[7]}}, b} :
                funct3 == F3_LBU ? {{(W-8){1'b0}}, b} :
                funct3 == F3_LH  ? {{(W-16){h[15]}}, h} :
                funct3 == F3_LHU ? {{(W-16){1'b0}}, h} :
                funct3 == F3_LW  ? word : '0;
        illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        misaligned = ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0]) ||
                     (funct3 == F3_LW && addr != 2'b00);
        bad = illegal | misaligned;
    end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, load writeback formatting and retired-instruction counter
module mem_wb_stage
    import riscv_pkg::*;
#(
    parameter int IS_DEPTH = riscv_pkg::IS_DEPTH,
    parameter int REGF_WIDTH = riscv_pkg::REGF_WIDTH,
    parameter int CNT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [IS_DEPTH-1:0]   mem_rd,
    input  logic [1:0]            mem_wb_sel,
    input  logic [2:0]            mem_funct3,
    input  logic [REGF_WIDTH-1:0] mem_alu_result,
    input  logic [REGF_WIDTH-1:0] mem_pc_plus4,
    input  logic [REGF_WIDTH-1:0] mem_load_data,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  regWrite,
    output logic [IS_DEPTH-1:0]   rd,
    output logic [REGF_WIDTH-1:0] data_wr,
    output logic                  wb_valid,
    output logic                  load_fault,
    output logic [CNT_WIDTH-1:0]  instret
);
    wb_sel_e sel;
    logic [REGF_WIDTH-1:0] ext;
    logic bad;
    logic fault;
    logic we;
    logic retire;
    logic [REGF_WIDTH-1:0] d;
    assign sel = wb_sel_e'(mem_wb_sel);
    load_extend #(.W(REGF_WIDTH)) u_ext (
        .word(mem_load_data),
        .addr(mem_alu_result[1:0]),
        .funct3(mem_funct3),
        .value(ext),
        .bad(bad)
    );
    // next WB entry is formed before the register so data_wr settles early in the cycle
    always_comb begin
        fault = mem_valid & (sel == WB_LOAD) & bad;
        we = mem_valid & mem_reg_write & ~fault & (|mem_rd) & (sel != WB_RSVD);
        retire = mem_valid & ~fault;
        d = (!mem_valid || fault) ? '0 :
            sel == WB_ALU  ? mem_alu_result :
            sel == WB_PC4  ? mem_pc_plus4 :
            sel == WB_LOAD ? ext : '0;
    end
    // reset beats flush beats stall; an idle capture loads the new entry and counts retirement
    always_ff @(posedge clk) begin
        if (rst) begin
            regWrite <= 1'b0;
            rd <= '0;
            data_wr <= '0;
            wb_valid <= 1'b0;
            load_fault <= 1'b0;
            instret <= '0;
        end else if (flush) begin
            regWrite <= 1'b0;
            rd <= '0;
            data_wr <= '0;
            wb_valid <= 1'b0;
            load_fault <= 1'b0;
        end else if (!stall) begin
            regWrite <= we;
            rd <= we ? mem_rd : '0;
            data_wr <= d;
            wb_valid <= mem_valid;
            load_fault <= fault;
            instret <= instret + CNT_WIDTH'(retire);
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for the MEM/WB stage
module tb_mem_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_valid = 1'b0;
    logic mem_reg_write = 1'b0;
    logic [4:0] mem_rd = '0;
    logic [1:0] mem_wb_sel = '0;
    logic [2:0] mem_funct3 = '0;
    logic [31:0] mem_alu_result = '0;
    logic [31:0] mem_pc_plus4 = '0;
    logic [31:0] mem_load_data = '0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic regWrite;
    logic [4:0] rd;
    logic [31:0] data_wr;
    logic wb_valid;
    logic load_fault;
    logic [63:0] instret;
    int tests = 0;
    int fails = 0;
    logic [63:0] cnt = '0;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_data(mem_load_data), .stall(stall), .flush(flush),
        .regWrite(regWrite), .rd(rd), .data_wr(data_wr), .wb_valid(wb_valid),
        .load_fault(load_fault), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic [4:0] r, input logic [1:0] s,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] ld);
        mem_valid = v;
        mem_reg_write = rw;
        mem_rd = r;
        mem_wb_sel = s;
        mem_funct3 = f3;
        mem_alu_result = alu;
        mem_pc_plus4 = pc4;
        mem_load_data = ld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 7, 2'b00, 3'b000, 32'h0000_0042, 32'h0, 32'h0);
        tick();
        tick();
        tests++;
        if ({regWrite, rd, data_wr, wb_valid, load_fault} !== 40'h0) begin
            fails++;
            $display("FAIL reset_outputs got rw=%b rd=%0d d=%h v=%b lf=%b want all 0", regWrite, rd, data_wr, wb_valid, load_fault);
        end
        tests++;
        if (instret !== 64'd0) begin fails++; $display("FAIL reset_instret got %0d want 0", instret); end
        rst = 1'b0;
        tick();
        cnt = 1;
        tests++;
        if (regWrite !== 1'b1 || rd !== 5'd7 || data_wr !== 32'h42) begin
            fails++;
            $display("FAIL reset_release got rw=%b rd=%0d d=%h want rw=1 rd=7 d=00000042", regWrite, rd, data_wr);
        end
        tests++;
        if (instret !== cnt) begin fails++; $display("FAIL reset_release_instret got %0d want %0d", instret, cnt); end
    endtask

    task automatic test_alu_pc4();
        drive(1, 1, 5, 2'b00, 3'b000, 32'h0000_1234, 32'h0000_0108, 32'h0);
        tick();
        cnt++;
        tests++;
        if (regWrite !== 1'b1 || rd !== 5'd5 || data_wr !== 32'h0000_1234 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL alu_wb got rw=%b rd=%0d d=%h v=%b want 1 5 00001234 1", regWrite, rd, data_wr, wb_valid);
        end
        mem_wb_sel = 2'b10;
        tick();
        cnt++;
        tests++;
        if (data_wr !== 32'h0000_0108 || regWrite !== 1'b1) begin
            fails++;
            $display("FAIL pc4_wb got d=%h rw=%b want 00000108 1", data_wr, regWrite);
        end
        tests++;
        if (instret !== cnt) begin fails++; $display("FAIL alu_instret got %0d want %0d", instret, cnt); end
        mem_wb_sel = 2'b11;
        tick();
        cnt++;
        tests++;
        if (regWrite !== 1'b0 || rd !== 5'd0 || data_wr !== 32'h0 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL rsvd_wb got rw=%b rd=%0d d=%h v=%b want 0 0 00000000 1", regWrite, rd, data_wr, wb_valid);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0] f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0] ads [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 3, 2'b01, f3s[i], {30'h400, ads[i]}, 32'h0, 32'h80FF_7F01);
            tick();
            cnt++;
            tests++;
            if (data_wr !== exps[i] || load_fault !== 1'b0 || regWrite !== 1'b1 || rd !== 5'd3) begin
                fails++;
                $display("FAIL load_ext[%0d] got d=%h lf=%b rw=%b rd=%0d want d=%h lf=0 rw=1 rd=3", i, data_wr, load_fault, regWrite, rd, exps[i]);
            end
        end
        tests++;
        if (instret !== cnt) begin fails++; $display("FAIL load_instret got %0d want %0d", instret, cnt); end
    endtask

    task automatic test_fault();
        logic [2:0] f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] ads [3] = '{32'h0000_1002, 32'h0000_1001, 32'h0000_1000};
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 4, 2'b01, f3s[i], ads[i], 32'h0, 32'h80FF_7F01);
            tick();
            tests++;
            if (load_fault !== 1'b1 || regWrite !== 1'b0 || data_wr !== 32'h0 || rd !== 5'd0 || wb_valid !== 1'b1) begin
                fails++;
                $display("FAIL fault[%0d] got lf=%b rw=%b d=%h rd=%0d v=%b want 1 0 00000000 0 1", i, load_fault, regWrite, data_wr, rd, wb_valid);
            end
            tests++;
            if (instret !== cnt) begin fails++; $display("FAIL fault_instret[%0d] got %0d want %0d", i, instret, cnt); end
        end
    endtask

    task automatic test_x0_invalid();
        drive(1, 1, 0, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick();
        cnt++;
        tests++;
        if (regWrite !== 1'b0 || rd !== 5'd0 || wb_valid !== 1'b1 || instret !== cnt) begin
            fails++;
            $display("FAIL x0_write got rw=%b rd=%0d v=%b cnt=%0d want 0 0 1 %0d", regWrite, rd, wb_valid, instret, cnt);
        end
        drive(0, 1, 6, 2'b00, 3'b000, 32'h1111_2222, 32'h0, 32'h0);
        tick();
        tests++;
        if ({regWrite, rd, data_wr, wb_valid, load_fault} !== 40'h0 || instret !== cnt) begin
            fails++;
            $display("FAIL invalid_entry got rw=%b rd=%0d d=%h v=%b cnt=%0d want bubble cnt=%0d", regWrite, rd, data_wr, wb_valid, instret, cnt);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 1, 9, 2'b00, 3'b000, 32'h0000_0055, 32'h0, 32'h0);
        tick();
        cnt++;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(10 + i), 2'b00, 3'b000, 32'hA000_0000 + 32'(i), 32'h0, 32'h0);
            tick();
            tests++;
            if (regWrite !== 1'b1 || rd !== 5'd9 || data_wr !== 32'h55 || instret !== cnt) begin
                fails++;
                $display("FAIL stall_hold[%0d] got rw=%b rd=%0d d=%h cnt=%0d want 1 9 00000055 %0d", i, regWrite, rd, data_wr, instret, cnt);
            end
        end
        flush = 1'b1;
        tick();
        tests++;
        if ({regWrite, rd, data_wr, wb_valid, load_fault} !== 40'h0 || instret !== cnt) begin
            fails++;
            $display("FAIL stall_flush got rw=%b rd=%0d d=%h v=%b cnt=%0d want bubble cnt=%0d", regWrite, rd, data_wr, wb_valid, instret, cnt);
        end
        flush = 1'b0;
        stall = 1'b0;
        tick();
        cnt++;
        tests++;
        if (regWrite !== 1'b1 || rd !== 5'd12 || data_wr !== 32'hA000_0002) begin
            fails++;
            $display("FAIL post_stall got rw=%b rd=%0d d=%h want 1 12 a0000002", regWrite, rd, data_wr);
        end
        stall = 1'b1;
        rst = 1'b1;
        tick();
        tests++;
        if ({regWrite, rd, data_wr, wb_valid, load_fault} !== 40'h0 || instret !== 64'd0) begin
            fails++;
            $display("FAIL reset_over_stall got rw=%b rd=%0d d=%h v=%b cnt=%0d want all 0", regWrite, rd, data_wr, wb_valid, instret);
        end
        rst = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_pc4();
        test_load_ext();
        test_fault();
        test_x0_invalid();
        test_stall_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register and writeback stage for the pipelined RV32I core. It captures the MEM-stage result once per cycle and performs load byte/half selection and sign/zero extension. Its registered outputs drive the register file write port (regWrite, rd, data_wr) and the forwarding unit. It also keeps the retired-instruction counter.

Parameters:
IS_DEPTH, 5, register address width
REGF_WIDTH, 32, data width of registers and datapath
CNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  in  1  core clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes rd
mem_rd  in  IS_DEPTH  destination register
mem_wb_sel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 reserved
mem_funct3  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
mem_alu_result  in  REGF_WIDTH  ALU result; byte address for loads
mem_pc_plus4  in  REGF_WIDTH  PC+4 for JAL/JALR
mem_load_data  in  REGF_WIDTH  raw aligned word from data memory
stall  in  1  hold WB contents
flush  in  1  insert bubble
regWrite  out  1  register file write enable
rd  out  IS_DEPTH  register file write address
data_wr  out  REGF_WIDTH  register file write data
wb_valid  out  1  WB holds a real instruction
load_fault  out  1  WB instruction is a faulting load
instret  out  CNT_WIDTH  retired-instruction count

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Latency: 1 cycle from mem_* inputs to outputs.
  - Extension and mux logic sit before the register, so data_wr is stable before the register file's negedge write (write-first-half, read-second-half).
- Edge priority, highest first:
  - rst: all outputs 0, instret 0.
  - flush: bubble. wb_valid, regWrite, load_fault, rd and data_wr all 0. instret unchanged.
  - stall: all registered outputs hold. instret unchanged. A held regWrite=1 rewrites the same value to the same rd, which is harmless.
  - Otherwise: capture the new entry.
- Capture rules:
  - wb_valid = mem_valid.
  - fault = mem_valid & (mem_wb_sel==01) & (illegal funct3 | misaligned).
    - Illegal funct3: any code outside LB/LH/LW/LBU/LHU.
    - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]≠00. LB/LBU are never misaligned.
  - load_fault = fault.
  - regWrite = mem_valid & mem_reg_write & ~fault & (mem_rd≠0) & (mem_wb_sel≠11). Writes to x0 are always suppressed.
  - rd = mem_rd when regWrite is set, else 0.
  - data_wr by mem_wb_sel:
    - 00: mem_alu_result.
    - 10: mem_pc_plus4.
    - 01: extended load value.
    - 11 or fault: 0.
- Load extension (little-endian):
  - Byte = load_data[8*addr[1:0] +: 8]; half = load_data[16*addr[1] +: 16].
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through.
- instret: increments by 1 on each capture edge with mem_valid=1 and no fault. Wraps modulo 2^CNT_WIDTH.
- Invalid entry (mem_valid=0): bubble with the same values as flush.
- Reset asserted mid-stall or mid-flush: reset wins on that edge.

Decomposition:
- Package riscv_pkg holds:
  - enum wb_sel_e (WB_ALU, WB_LOAD, WB_PC4, WB_RSVD).
  - Load funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - REGF_WIDTH/IS_DEPTH defaults.
- Sub-module load_extend: combinational. Inputs word, addr[1:0], funct3. Outputs value and misaligned/illegal flag. Instantiated once.

Test Plan:
- Reset: rst=1 for 2 cycles while mem_valid=1, mem_reg_write=1, mem_rd=7 → all outputs 0, instret=0. After release with inputs unchanged → regWrite=1, rd=7, instret=1.
- ALU writeback: rd=5, wb_sel=00, alu=0x00001234 → next cycle regWrite=1, rd=5, data_wr=0x00001234, wb_valid=1. Same setup with wb_sel=10, pc_plus4=0x00000108 → data_wr=0x00000108.
- Load extension, load_data=0x80FF7F01:
  - LB addr 0x...3 → data_wr=0xFFFFFF80.
  - LBU addr 0x...2 → 0x000000FF.
  - LH addr 0x...2 → 0xFFFF80FF.
  - LHU addr 0x...0 → 0x00007F01.
  - LW addr 0x...0 → 0x80FF7F01.
- Faults:
  - LW addr 0x1002 → load_fault=1, regWrite=0, data_wr=0, instret unchanged.
  - LH addr 0x...1 → same result.
  - funct3=011 with wb_sel=01 → same result.
- x0 write: mem_reg_write=1, rd=0, alu=0xDEADBEEF → regWrite=0, rd=0, wb_valid=1, instret increments.
- Stall/flush:
  - Capture rd=9 data 0x55, then stall=1 for 3 cycles while inputs change → outputs hold rd=9/0x55, instret constant.
  - stall=1 and flush=1 together → bubble (wb_valid=0, regWrite=0).
